// File: rtl/pulsador_ctrl_if.sv
// Handshake bundle between the button front end and the LED counter.
// Master drives the button level and enable; slave returns command strobes.
interface pulsador_ctrl_if;
  logic       btn_db;
  logic       en;
  logic       inc;
  logic       clr;
  logic       long_act;
  logic [1:0] state;

  modport master (
    output btn_db,
    output en,
    input  inc,
    input  clr,
    input  long_act,
    input  state
  );

  modport slave (
    input  btn_db,
    input  en,
    output inc,
    output clr,
    output long_act,
    output state
  );
endinterface

// File: rtl/pulsador_ctrl.sv
// Press-gesture controller: short press, auto-repeat and long-hold clear.
// All outputs are registered single-cycle strobes for the LED counter.
module pulsador_ctrl #(
  parameter int CNT_W      = 27,
  parameter int LONG_CYC   = 27_000_000,
  parameter int REPEAT_CYC = 5_400_000,
  parameter int CLEAR_CYC  = 81_000_000
) (
  input logic            clk,
  input logic            rst,
  pulsador_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_M1  = CNT_W'(CLEAR_CYC - 1);

  state_t           st;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] rtmr;
  logic             inc_q;
  logic             clr_q;
  logic             long_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      tmr    <= '0;
      rtmr   <= '0;
      inc_q  <= 1'b0;
      clr_q  <= 1'b0;
      long_q <= 1'b0;
    end else begin
      inc_q  <= 1'b0;
      clr_q  <= 1'b0;
      long_q <= 1'b0;
      if (!bus.en) begin
        st   <= IDLE;
        tmr  <= '0;
        rtmr <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            if (bus.btn_db) begin
              st   <= PRESS;
              tmr  <= '0;
              rtmr <= '0;
            end
          end
          PRESS: begin
            if (!bus.btn_db) begin
              st    <= IDLE;
              inc_q <= 1'b1;
              tmr   <= '0;
            end else if (tmr == LONG_M1) begin
              st     <= REPEAT;
              inc_q  <= 1'b1;
              long_q <= 1'b1;
              rtmr   <= '0;
              tmr    <= tmr + 1'b1;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          REPEAT: begin
            if (!bus.btn_db) begin
              st   <= IDLE;
              tmr  <= '0;
              rtmr <= '0;
            end else if (tmr == CLR_M1) begin
              // clear wins over a coincident repeat tick
              st    <= WAIT_REL;
              clr_q <= 1'b1;
            end else begin
              long_q <= 1'b1;
              tmr    <= tmr + 1'b1;
              if (rtmr == REP_M1) begin
                inc_q <= 1'b1;
                rtmr  <= '0;
              end else begin
                rtmr <= rtmr + 1'b1;
              end
            end
          end
          WAIT_REL: begin
            if (!bus.btn_db) begin
              st   <= IDLE;
              tmr  <= '0;
              rtmr <= '0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign bus.inc      = inc_q;
  assign bus.clr      = clr_q;
  assign bus.long_act = long_q;
  assign bus.state    = st;

endmodule

// File: doc/pulsador_ctrl.md
Name: pulsador_ctrl

Overview:
- Press-gesture controller between the debounce/synchroniser stage and the 6-bit LED counter datapath.
- Takes the clean, synchronised button level and decides what the counter does:
  - short press → one increment on release;
  - long hold → auto-repeat increments;
  - very long hold → clear.
- Emits single-cycle command strobes to the counter; has no knowledge of the count value.

Parameters:
- CNT_W, 27, width of the internal press timers. Must satisfy 2^CNT_W > CLEAR_CYC.
- LONG_CYC, 27_000_000, hold cycles before auto-repeat starts (1 s at 27 MHz). Must be ≥2.
- REPEAT_CYC, 5_400_000, cycles between auto-repeat increments (200 ms). Must be ≥2.
- CLEAR_CYC, 81_000_000, hold cycles before a clear is issued (3 s). Must be > LONG_CYC.

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  asynchronous, active-high reset
- btn_db  in  1  debounced, synchronised button level (1 = pressed)
- en  in  1  controller enable; 0 forces IDLE and suppresses all strobes
- inc  out  1  one-cycle increment strobe to LED counter
- clr  out  1  one-cycle clear strobe to LED counter
- long_act  out  1  high while in REPEAT state
- state  out  2  FSM state for debug: IDLE=0, PRESS=1, REPEAT=2, WAIT_REL=3

Behaviour:
- Timing and reset
  - Single clock domain; all outputs registered.
  - Interface fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
  - rst=1, including mid-operation → state=IDLE, both timers=0, inc=0, clr=0, long_act=0 immediately. No pulse is generated on reset release.
- Timers
  - tmr: total cycles since press accepted.
  - rtmr: cycles since last repeat.
  - Both are CNT_W bits, cleared on every state entry listed below, and never wrap (CLEAR_CYC bound).
- IDLE
  - en=1 and btn_db=1 → PRESS; tmr=0.
  - Otherwise stay in IDLE.
- PRESS (tmr increments each cycle)
  - btn_db=0 → IDLE; inc=1 for the following cycle (short press).
  - btn_db=1 and tmr==LONG_CYC-1 → REPEAT; inc=1 (first repeat); rtmr=0.
  - A button already high when en rises is accepted as a new press.
- REPEAT (tmr and rtmr increment each cycle; long_act=1)
  - btn_db=0 → IDLE, no strobe.
  - tmr==CLEAR_CYC-1 → WAIT_REL; clr=1. This has priority: if rtmr==REPEAT_CYC-1 in the same cycle, clr only, no inc.
  - Else rtmr==REPEAT_CYC-1 → inc=1; rtmr=0.
- WAIT_REL
  - Holds until btn_db=0, then → IDLE. No strobes.
  - Prevents re-increment after a clear.
- Enable
  - en=0 in any state → IDLE on the next edge; inc, clr and long_act forced 0 in that same cycle.
  - A release pending in PRESS is discarded (no inc).
- Strobe rules
  - inc and clr are never high together.
  - Each is high for exactly one cycle per event.
  - Pulse edge is counted from the edge that entered PRESS (edge 0).

Test Plan (bench uses LONG_CYC=10, REPEAT_CYC=4, CLEAR_CYC=30, CNT_W=6; edge 0 = edge entering PRESS):
- Short press: btn_db high 3 cycles then low → exactly one inc pulse, one cycle after release sampled; clr never high; long_act stays 0.
- Auto-repeat: btn_db high 20 cycles then low → inc at edges +10, +14, +18 (3 pulses); long_act=1 from +10 until release; no inc on release.
- Clear priority: btn_db high 40 cycles → inc at +10, +14, +18, +22, +26 (5 pulses); at +30 clr=1 and inc=0; state=WAIT_REL; no further strobes until release; IDLE after btn_db=0.
- Enable gating: en=0 while btn_db toggles → no strobes, state=0. Drop en at +5 of a press, then release → no inc, IDLE next edge.
- Async reset mid-REPEAT: assert rst at +12 between clock edges → outputs 0 and state=0 before the next edge. Release rst with btn_db still high → new press accepted; first inc at +10 from the new PRESS entry.
- Bounce-free back-to-back: five 3-cycle presses separated by 2 idle cycles → exactly 5 inc pulses, 0 clr.
